// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing NUM_REGS byte registers behind an auto-incrementing pointer.
// Both bus lines are synchronised and glitch-filtered before any decoding.
`timescale 1ns/1ps
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'b1010001,
  parameter int         NUM_REGS      = 16,
  parameter int         FILTER_LEN    = 4,
  localparam int        PTR_W         = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  inout  wire              sda,
  input  logic [PTR_W-1:0] loc_rd_addr,
  output logic [7:0]       loc_rd_data,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  // Index 0 carries sclk, index 1 carries sda.
  logic [1:0]       w_raw;
  logic [1:0]       r_meta;
  logic [1:0]       r_sync;
  logic [1:0]       r_filt;
  logic [1:0]       r_filt_d;
  logic [3:0]       r_flt_cnt [2];

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_bit_cnt;
  logic [3:0]       w_bit_cnt_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             r_sda_oe;
  logic             w_oe_nxt;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic             r_rw;
  logic             w_rw_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_wr_strobe;
  logic             w_wr_en;
  logic [PTR_W-1:0] r_wr_addr;
  logic [PTR_W-1:0] w_wr_addr_nxt;
  logic [7:0]       r_wr_data;
  logic [7:0]       w_wr_data_nxt;
  logic [7:0]       r_regs [NUM_REGS];

  logic             w_scl;
  logic             w_sda;
  logic             w_scl_rise;
  logic             w_scl_fall;
  logic             w_start;
  logic             w_stop;
  logic             w_rx_state;
  logic             w_byte_done;
  logic [7:0]       w_byte;
  logic [3:0]       w_bit_inc;
  logic [PTR_W-1:0] w_ptr_inc;
  logic [7:0]       w_ptr_data;
  logic [7:0]       w_next_data;

  assign w_raw = {sda, sclk};
  assign sda   = r_sda_oe ? 1'b0 : 1'bz;

  // Two-flop synchroniser for both bus lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 2'b11;
      r_sync <= 2'b11;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
    end
  end

  // Glitch filter: a new level is accepted only after FILTER_LEN stable cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt       <= 2'b11;
      r_filt_d     <= 2'b11;
      r_flt_cnt[0] <= 4'd0;
      r_flt_cnt[1] <= 4'd0;
    end else begin
      r_filt_d <= r_filt;
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_filt[i]) begin
          r_flt_cnt[i] <= 4'd0;
        end else if (r_flt_cnt[i] == 4'(FILTER_LEN - 1)) begin
          r_filt[i]    <= r_sync[i];
          r_flt_cnt[i] <= 4'd0;
        end else begin
          r_flt_cnt[i] <= r_flt_cnt[i] + 4'd1;
        end
      end
    end
  end

  assign w_scl       = r_filt[0];
  assign w_sda       = r_filt[1];
  assign w_scl_rise  = w_scl & ~r_filt_d[0];
  assign w_scl_fall  = ~w_scl & r_filt_d[0];
  assign w_start     = w_scl & r_filt_d[0] & ~w_sda & r_filt_d[1];
  assign w_stop      = w_scl & r_filt_d[0] & w_sda & ~r_filt_d[1];
  assign w_rx_state  = (r_state == ADDR) || (r_state == PTR) || (r_state == WDATA);
  assign w_byte_done = w_scl_rise && (r_bit_cnt == 4'd7);
  assign w_byte      = {r_shift[6:0], w_sda};
  assign w_bit_inc   = r_bit_cnt + 4'd1;
  assign w_ptr_inc   = (r_ptr == PTR_W'(NUM_REGS - 1)) ? '0 : r_ptr + PTR_W'(1);
  assign w_ptr_data  = r_regs[r_ptr];
  assign w_next_data = r_regs[w_ptr_inc];

  // Protocol FSM: next-state and datapath updates
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_oe_nxt      = r_sda_oe;
    w_ptr_nxt     = r_ptr;
    w_rw_nxt      = r_rw;
    w_busy_nxt    = r_busy;
    w_wr_en       = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    if (w_stop) begin
      w_state_nxt   = IDLE;
      w_oe_nxt      = 1'b0;
      w_busy_nxt    = 1'b0;
      w_bit_cnt_nxt = 4'd0;
    end else if (w_start) begin
      w_state_nxt   = ADDR;
      w_oe_nxt      = 1'b0;
      w_bit_cnt_nxt = 4'd0;
    end else begin
      if (w_rx_state && w_scl_rise) begin
        w_shift_nxt   = w_byte;
        w_bit_cnt_nxt = w_byte_done ? 4'd0 : w_bit_inc;
      end else begin
        w_shift_nxt = r_shift;
      end
      case (r_state)
        ADDR: begin
          if (w_byte_done && (w_byte[7:1] == SLAVE_ADDRESS)) begin
            w_state_nxt = ADDR_ACK;
            w_rw_nxt    = w_byte[0];
            w_busy_nxt  = 1'b1;
          end else if (w_byte_done) begin
            w_state_nxt = WAIT_STOP;
          end else begin
            w_state_nxt = r_state;
          end
        end
        PTR: begin
          if (w_byte_done && ({1'b0, w_byte} < 9'(NUM_REGS))) begin
            w_ptr_nxt   = w_byte[PTR_W-1:0];
            w_state_nxt = PTR_ACK;
          end else if (w_byte_done) begin
            w_state_nxt = WAIT_STOP;
          end else begin
            w_state_nxt = r_state;
          end
        end
        WDATA: begin
          if (w_byte_done) begin
            w_wr_en       = 1'b1;
            w_wr_addr_nxt = r_ptr;
            w_wr_data_nxt = w_byte;
            w_ptr_nxt     = w_ptr_inc;
            w_state_nxt   = WDATA_ACK;
          end else begin
            w_state_nxt = r_state;
          end
        end
        // First falling edge starts the ACK, the second ends it
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (w_scl_fall && !r_sda_oe) begin
            w_oe_nxt = 1'b1;
          end else if (w_scl_fall) begin
            w_oe_nxt      = 1'b0;
            w_bit_cnt_nxt = 4'd0;
            if ((r_state == ADDR_ACK) && r_rw) begin
              w_state_nxt = RDATA;
              w_shift_nxt = w_ptr_data;
              w_oe_nxt    = ~w_ptr_data[7];
            end else if (r_state == ADDR_ACK) begin
              w_state_nxt = PTR;
            end else begin
              w_state_nxt = WDATA;
            end
          end else begin
            w_oe_nxt = r_sda_oe;
          end
        end
        RDATA: begin
          if (w_scl_rise) begin
            w_bit_cnt_nxt = w_bit_inc;
          end else if (w_scl_fall && r_bit_cnt[3]) begin
            w_oe_nxt    = 1'b0;
            w_state_nxt = RDATA_ACK;
          end else if (w_scl_fall) begin
            w_oe_nxt = ~r_shift[3'd7 - r_bit_cnt[2:0]];
          end else begin
            w_oe_nxt = r_sda_oe;
          end
        end
        RDATA_ACK: begin
          if (w_scl_rise && !w_sda) begin
            w_ptr_nxt     = w_ptr_inc;
            w_shift_nxt   = w_next_data;
            w_bit_cnt_nxt = 4'd0;
            w_state_nxt   = RDATA;
          end else if (w_scl_rise) begin
            w_state_nxt = WAIT_STOP;
          end else begin
            w_state_nxt = r_state;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'h00;
      r_sda_oe    <= 1'b0;
      r_ptr       <= '0;
      r_rw        <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_sda_oe    <= w_oe_nxt;
      r_ptr       <= w_ptr_nxt;
      r_rw        <= w_rw_nxt;
      r_busy      <= w_busy_nxt;
      r_wr_strobe <= w_wr_en;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
    end
  end

  // Register file, written only on a completed WDATA byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else if (w_wr_en) begin
      r_regs[r_ptr] <= w_byte;
    end else begin
      r_regs[r_ptr] <= r_regs[r_ptr];
    end
  end

  generate
    if (NUM_REGS == (2 ** PTR_W)) begin : g_rd_full
      assign loc_rd_data = r_regs[loc_rd_addr];
    end else begin : g_rd_partial
      assign loc_rd_data = ({1'b0, loc_rd_addr} < (PTR_W + 1)'(NUM_REGS)) ? r_regs[loc_rd_addr] : 8'h00;
    end
  endgenerate

  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;

endmodule

// File: doc/i2c_slave_regfile.md
I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

Interface
REQ-001 Parameter SLAVE_ADDRESS, default 7'b1010001, is the 7-bit device address this block answers to.
REQ-002 Parameter NUM_REGS, default 16, range 2..256, is the register count; PTR_W = clog2(NUM_REGS).
REQ-003 Parameter FILTER_LEN, default 4, range 1..15, is the number of clk cycles an input must be stable before the filtered value changes.
REQ-004 Port clk, input, 1 bit: system clock; clk SHALL be at least 16x the sclk rate.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port sclk, input, 1 bit: I2C clock from the master.
REQ-007 Port sda, inout, 1 bit: open-drain I2C data; the block drives only 1'b0, otherwise 1'bz.
REQ-008 Port loc_rd_addr, input, PTR_W bits: local read address.
REQ-009 Port loc_rd_data, output, 8 bits: register[loc_rd_addr], combinational.
REQ-010 Port wr_strobe, output, 1 bit: one-clk pulse per register written over I2C.
REQ-011 Port wr_addr, output, PTR_W bits: register index of the current wr_strobe.
REQ-012 Port wr_data, output, 8 bits: byte written for the current wr_strobe.
REQ-013 Port busy, output, 1 bit: high from address match until stop.

Function
REQ-014 sclk and sda SHALL pass through a 2-FF synchroniser, then the FILTER_LEN glitch filter; all decoding SHALL use the filtered signals only.
REQ-015 START = filtered sda 1->0 while filtered sclk is high; STOP = filtered sda 0->1 while filtered sclk is high; each is a one-clk internal pulse.
REQ-016 Data SHALL be sampled on the filtered sclk rising edge; the block SHALL change its sda drive only on the filtered sclk falling edge; bytes are MSB first.
REQ-017 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-018 START from any state, including a repeated start, -> ADDR with the bit counter cleared; STOP from any state -> IDLE with sda released.
REQ-019 ADDR: after 8 bits, if byte[7:1]==SLAVE_ADDRESS -> ADDR_ACK; otherwise -> WAIT_STOP with sda never driven.
REQ-020 ACK = drive sda low from the falling edge after bit 8 to the falling edge after bit 9.
REQ-021 ADDR_ACK then: R/W=0 -> PTR; R/W=1 -> RDATA, which loads register[ptr] for transmit.
REQ-022 PTR: a received byte < NUM_REGS is ACKed and loads ptr -> PTR_ACK -> WDATA; a byte >= NUM_REGS is NACKed -> WAIT_STOP with ptr unchanged.
REQ-023 WDATA: each received byte is ACKed, written to register[ptr], and pulses wr_strobe with wr_addr=ptr and wr_data=byte in the clk after the 8th rising edge; ptr then increments.
REQ-024 RDATA: the block drives register[ptr] bits (zeros driven low, ones released); at the 9th rising edge the master ACK (sda=0) increments ptr and loads the next byte, and the master NACK -> WAIT_STOP.
REQ-025 ptr increment SHALL wrap from NUM_REGS-1 to 0.
REQ-026 ptr SHALL persist across transactions, so a write of the pointer only, a repeated start, and a read returns register[ptr].
REQ-027 A START or STOP arriving mid-byte SHALL discard the partial byte with no register write.
REQ-028 busy SHALL be set on address match and cleared on STOP; a START alone SHALL NOT clear busy.

Reset
REQ-029 With rst_n low, asynchronously: state=IDLE, sda released, ptr=0, all registers=8'h00, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, synchroniser and filter outputs=1.
REQ-030 Reset asserted mid-transfer SHALL release sda within the same clk cycle, with no further wr_strobe.
REQ-031 After reset release the block SHALL ignore the bus until the first valid START.

Verification
REQ-032 Write: START, 0xA2, 0x03, 0x5A, 0xC3, STOP -> all four bytes ACKed; reg3=0x5A, reg4=0xC3; two wr_strobe pulses (3/0x5A, then 4/0xC3).
REQ-033 Read: START, 0xA2, 0x03, repeated START, 0xA3, read 2 bytes with ACK then NACK, STOP -> master receives 0x5A, 0xC3; busy=0 after STOP.
REQ-034 Wrong address: START, 0xB0, 0x11, STOP -> sda never driven low, no wr_strobe, busy stays 0.
REQ-035 Wrap/range, NUM_REGS=16: write ptr 0x0F with data 0x11, 0x22 -> reg15=0x11, reg0=0x22; pointer 0x10 -> NACK, no write.
REQ-036 Glitch/abort: a 2-clk sclk glitch with FILTER_LEN=4 causes no bit shift; a STOP after 4 data bits causes no wr_strobe and state=IDLE.
REQ-037 rst_n pulsed low during RDATA while the block is driving sda=0 -> sda=z immediately; loc_rd_data reads 0x00 for every address.
